// File: rtl/fifo_burst_pkg.sv
// Shared types and helpers for the show-ahead FIFO burst read controller.
package fifo_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        LAST  = 2'd2
    } state_e;

    // Number of beats to emit: whatever is queued, capped at a full burst.
    function automatic int unsigned min_len(input int unsigned cnt, input int unsigned burst);
        return (cnt < burst) ? cnt : burst;
    endfunction

endpackage

// File: rtl/fifo_burst_rd_stream_out_reg.sv
// Output beat register: holds valid/data/last stable while the consumer
// stalls, and allows a new beat to replace the current one in the same
// cycle it is accepted so a held-high ready sustains one beat per cycle.
module stream_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  last_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  last_o
);

    // Load a new beat, retire an accepted beat, or hold while stalled.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i) begin
            valid_o <= 1'b0;
            dat_o   <= '0;
            last_o  <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            dat_o   <= dat_i;
            last_o  <= last_i;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_burst_rd.sv
// Read-side controller that drains a show-ahead FIFO into fixed-size bursts
// on a registered valid/ready stream, releasing partial bursts on timeout.
module fifo_burst_rd
    import fifo_burst_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8,
    parameter int CNT_WIDTH    = $clog2(BUFFER_DEPTH) + 1,
    parameter int BURST_LEN    = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [CNT_WIDTH-1:0]  fifo_cnt_i,
    input  logic [DATA_WIDTH-1:0] fifo_dat_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  last_o,
    output logic                  busy_o
);

    localparam int REM_W = $clog2(BURST_LEN + 1);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LEN);
    localparam logic [TMR_W-1:0]     TMR_MAX   = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   remCnt_q, remCnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               pop;
    logic               loadLast;
    logic               timeoutHit;
    logic               validOut;

    assign timeoutHit = (TIMEOUT != 0) && (fifo_cnt_i != '0) && (timer_q == TMR_MAX);

    // Next-state, beat counting, idle timer and pop generation; flush overrides all.
    always_comb begin
        state_d  = state_q;
        remCnt_d = remCnt_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        loadLast = 1'b0;
        if (flush_i) begin
            state_d  = IDLE;
            remCnt_d = '0;
            timer_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((fifo_cnt_i >= BURST_CNT) || timeoutHit) begin
                        state_d  = BURST;
                        remCnt_d = REM_W'(min_len(32'(fifo_cnt_i), 32'(BURST_LEN)));
                        timer_d  = '0;
                    end else if (fifo_cnt_i == '0) begin
                        timer_d = '0;
                    end else if (timer_q != TMR_MAX) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                BURST: begin
                    timer_d = '0;
                    pop     = ~fifo_empty_i & (~validOut | ready_i);
                    if (pop) begin
                        remCnt_d = remCnt_q - REM_W'(1);
                        if (remCnt_q == REM_W'(1)) begin
                            loadLast = 1'b1;
                            state_d  = LAST;
                        end
                    end
                end
                LAST: begin
                    timer_d = '0;
                    if (validOut && ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    remCnt_d = '0;
                    timer_d  = '0;
                end
            endcase
        end
    end

    // State, remaining-beat counter and idle timer registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            remCnt_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            remCnt_q <= remCnt_d;
            timer_q  <= timer_d;
        end
    end

    stream_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) uOutReg (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (flush_i),
        .load_i  (pop),
        .dat_i   (fifo_dat_i),
        .last_i  (loadLast),
        .ready_i (ready_i),
        .valid_o (validOut),
        .dat_o   (dat_o),
        .last_o  (last_o)
    );

    assign valid_o    = validOut;
    assign fifo_pop_o = pop;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_burst_rd.sv
// Directed bench for fifo_burst_rd: three instances (default, no timeout,
// single-beat bursts), each fed by its own show-ahead FIFO model.
module tb_fifo_burst_rd;

    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct {
        logic          ready;
        logic          expValid;
        logic [DW-1:0] expDat;
        logic          expLast;
        logic          expBusy;
        logic          expPop;
    } vec_t;

    logic clk_i = 1'b0;
    logic rstN;
    logic readyIn;
    logic flushIn;

    logic [2:0]         pop, empty, valid, last, busy;
    logic [2:0][CW-1:0] cnt;
    logic [2:0][DW-1:0] datIn, datOut;

    logic [DW-1:0] mem [3][16];
    logic [3:0]    wrPtr [3];
    logic [3:0]    rdPtr [3];
    logic [2:0]    clrReq;

    int nChecks = 0;
    int nFail   = 0;

    vec_t t1[$];
    vec_t t3[$];

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Show-ahead FIFO models: head word and occupancy are combinational.
    for (genvar g = 0; g < 3; g++) begin : gModel
        assign cnt[g]   = wrPtr[g] - rdPtr[g];
        assign empty[g] = (cnt[g] == '0);
        assign datIn[g] = mem[g][rdPtr[g]];
    end

    // Read pointers advance on each pop; a clear request empties a model.
    always @(posedge clk_i) begin
        for (int i = 0; i < 3; i++) begin
            if (clrReq[i]) rdPtr[i] <= wrPtr[i];
            else if (pop[i]) rdPtr[i] <= rdPtr[i] + 4'd1;
        end
    end

    fifo_burst_rd #(.DATA_WIDTH(DW), .BUFFER_DEPTH(8), .BURST_LEN(4), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_n_i(rstN), .flush_i(flushIn),
        .fifo_empty_i(empty[0]), .fifo_cnt_i(cnt[0]), .fifo_dat_i(datIn[0]),
        .fifo_pop_o(pop[0]), .valid_o(valid[0]), .ready_i(readyIn),
        .dat_o(datOut[0]), .last_o(last[0]), .busy_o(busy[0]));

    fifo_burst_rd #(.DATA_WIDTH(DW), .BUFFER_DEPTH(8), .BURST_LEN(4), .TIMEOUT(0)) dutNoTimeout (
        .clk_i(clk_i), .rst_n_i(rstN), .flush_i(flushIn),
        .fifo_empty_i(empty[1]), .fifo_cnt_i(cnt[1]), .fifo_dat_i(datIn[1]),
        .fifo_pop_o(pop[1]), .valid_o(valid[1]), .ready_i(readyIn),
        .dat_o(datOut[1]), .last_o(last[1]), .busy_o(busy[1]));

    fifo_burst_rd #(.DATA_WIDTH(DW), .BUFFER_DEPTH(8), .BURST_LEN(1), .TIMEOUT(16)) dutSingle (
        .clk_i(clk_i), .rst_n_i(rstN), .flush_i(flushIn),
        .fifo_empty_i(empty[2]), .fifo_cnt_i(cnt[2]), .fifo_dat_i(datIn[2]),
        .fifo_pop_o(pop[2]), .valid_o(valid[2]), .ready_i(readyIn),
        .dat_o(datOut[2]), .last_o(last[2]), .busy_o(busy[2]));

    function automatic vec_t mk(input logic r, input logic v, input logic [DW-1:0] d,
                                input logic l, input logic b, input logic p);
        vec_t x;
        x.ready = r; x.expValid = v; x.expDat = d; x.expLast = l; x.expBusy = b; x.expPop = p;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input logic rdy, input logic fl);
        readyIn = rdy;
        flushIn = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkDut(input int id, input string tag, input logic ev, input logic [DW-1:0] ed,
                            input logic el, input logic eb, input logic ep);
        checkOutput({tag, " valid"}, DW'(valid[id]), DW'(ev));
        checkOutput({tag, " last"},  DW'(last[id]),  DW'(el));
        checkOutput({tag, " busy"},  DW'(busy[id]),  DW'(eb));
        checkOutput({tag, " pop"},   DW'(pop[id]),   DW'(ep));
        if (ev) checkOutput({tag, " dat"}, datOut[id], ed);
    endtask

    task automatic pushWord(input int id, input logic [DW-1:0] d);
        mem[id][wrPtr[id]] = d;
        wrPtr[id] = wrPtr[id] + 4'd1;
    endtask

    task automatic clearModel(input int id);
        clrReq[id] = 1'b1;
        tick();
        clrReq[id] = 1'b0;
    endtask

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main directed sequence.
    initial begin
        // Full 4-beat burst, ready held high.
        t1.push_back(mk(1, 0, 0,        0, 0, 0));
        t1.push_back(mk(1, 0, 0,        0, 1, 1));
        t1.push_back(mk(1, 1, 32'hA0,   0, 1, 1));
        t1.push_back(mk(1, 1, 32'hA1,   0, 1, 1));
        t1.push_back(mk(1, 1, 32'hA2,   0, 1, 1));
        t1.push_back(mk(1, 1, 32'hA3,   1, 1, 0));
        t1.push_back(mk(1, 0, 0,        0, 0, 0));
        // Two bursts of 8 queued words, ready toggling 1,0,0.
        t3.push_back(mk(1, 0, 0,        0, 0, 0));
        t3.push_back(mk(0, 0, 0,        0, 1, 1));
        t3.push_back(mk(0, 1, 32'hC0,   0, 1, 0));
        t3.push_back(mk(1, 1, 32'hC0,   0, 1, 1));
        t3.push_back(mk(0, 1, 32'hC1,   0, 1, 0));
        t3.push_back(mk(0, 1, 32'hC1,   0, 1, 0));
        t3.push_back(mk(1, 1, 32'hC1,   0, 1, 1));
        t3.push_back(mk(0, 1, 32'hC2,   0, 1, 0));
        t3.push_back(mk(0, 1, 32'hC2,   0, 1, 0));
        t3.push_back(mk(1, 1, 32'hC2,   0, 1, 1));
        t3.push_back(mk(0, 1, 32'hC3,   1, 1, 0));
        t3.push_back(mk(0, 1, 32'hC3,   1, 1, 0));
        t3.push_back(mk(1, 1, 32'hC3,   1, 1, 0));
        t3.push_back(mk(0, 0, 0,        0, 0, 0));
        t3.push_back(mk(0, 0, 0,        0, 1, 1));
        t3.push_back(mk(1, 1, 32'hC4,   0, 1, 1));
        t3.push_back(mk(0, 1, 32'hC5,   0, 1, 0));
        t3.push_back(mk(0, 1, 32'hC5,   0, 1, 0));
        t3.push_back(mk(1, 1, 32'hC5,   0, 1, 1));
        t3.push_back(mk(0, 1, 32'hC6,   0, 1, 0));
        t3.push_back(mk(0, 1, 32'hC6,   0, 1, 0));
        t3.push_back(mk(1, 1, 32'hC6,   0, 1, 1));
        t3.push_back(mk(0, 1, 32'hC7,   1, 1, 0));
        t3.push_back(mk(0, 1, 32'hC7,   1, 1, 0));
        t3.push_back(mk(1, 1, 32'hC7,   1, 1, 0));
        t3.push_back(mk(0, 0, 0,        0, 0, 0));

        for (int i = 0; i < 3; i++) wrPtr[i] = '0;
        clrReq  = '1;
        rstN    = 1'b0;
        readyIn = 1'b0;
        flushIn = 1'b0;
        tick();
        tick();
        applyStimulus(0, 0);
        checkDut(0, "reset", 0, 0, 0, 0, 0);
        checkOutput("reset dat", datOut[0], 0);
        checkDut(2, "reset single", 0, 0, 0, 0, 0);
        rstN   = 1'b1;
        clrReq = '0;
        tick();

        $display("[TB] full burst");
        for (int w = 0; w < 4; w++) pushWord(0, 32'hA0 + DW'(w));
        for (int r = 0; r < t1.size(); r++) begin
            applyStimulus(t1[r].ready, 0);
            checkDut(0, $sformatf("full r%0d", r), t1[r].expValid, t1[r].expDat,
                     t1[r].expLast, t1[r].expBusy, t1[r].expPop);
            tick();
        end

        $display("[TB] timeout partial burst");
        pushWord(0, 32'hB0); pushWord(0, 32'hB1);
        pushWord(1, 32'hB0); pushWord(1, 32'hB1);
        for (int r = 0; r < 40; r++) begin
            applyStimulus(1, 0);
            if (r < 16)       checkDut(0, $sformatf("tmo r%0d", r), 0, 0, 0, 0, 0);
            else if (r == 16) checkDut(0, "tmo r16", 0, 0, 0, 1, 1);
            else if (r == 17) checkDut(0, "tmo r17", 1, 32'hB0, 0, 1, 1);
            else if (r == 18) checkDut(0, "tmo r18", 1, 32'hB1, 1, 1, 0);
            else if (r == 19) checkDut(0, "tmo r19", 0, 0, 0, 0, 0);
            checkDut(1, $sformatf("notmo r%0d", r), 0, 0, 0, 0, 0);
            tick();
        end

        $display("[TB] stalled double burst");
        for (int w = 0; w < 8; w++) pushWord(0, 32'hC0 + DW'(w));
        for (int r = 0; r < t3.size(); r++) begin
            applyStimulus(t3[r].ready, 0);
            checkDut(0, $sformatf("stall r%0d", r), t3[r].expValid, t3[r].expDat,
                     t3[r].expLast, t3[r].expBusy, t3[r].expPop);
            tick();
        end

        $display("[TB] flush");
        for (int w = 0; w < 4; w++) pushWord(0, 32'hD0 + DW'(w));
        applyStimulus(1, 0); checkDut(0, "flush r0", 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 0); checkDut(0, "flush r1", 0, 0, 0, 1, 1); tick();
        applyStimulus(1, 0); checkDut(0, "flush r2", 1, 32'hD0, 0, 1, 1); tick();
        applyStimulus(1, 0); checkDut(0, "flush r3", 1, 32'hD1, 0, 1, 1); tick();
        applyStimulus(0, 0); checkDut(0, "flush r4", 1, 32'hD2, 0, 1, 0); tick();
        applyStimulus(0, 1); checkDut(0, "flush r5", 1, 32'hD2, 0, 1, 0); tick();
        applyStimulus(0, 0); checkDut(0, "flush r6", 0, 0, 0, 0, 0);
        clearModel(0);
        for (int w = 0; w < 4; w++) pushWord(0, 32'hE0 + DW'(w));
        applyStimulus(1, 0); checkDut(0, "flush r7", 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 1); checkDut(0, "flush popgate", 0, 0, 0, 1, 0); tick();
        applyStimulus(1, 1); checkDut(0, "flush idle", 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 0); checkDut(0, "flush trigger ignored", 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 0); checkDut(0, "fresh r0", 0, 0, 0, 1, 1); tick();
        applyStimulus(1, 0); checkDut(0, "fresh r1", 1, 32'hE0, 0, 1, 1); tick();
        applyStimulus(1, 0); checkDut(0, "fresh r2", 1, 32'hE1, 0, 1, 1); tick();
        applyStimulus(1, 0); checkDut(0, "fresh r3", 1, 32'hE2, 0, 1, 1); tick();
        applyStimulus(1, 0); checkDut(0, "fresh r4", 1, 32'hE3, 1, 1, 0); tick();
        applyStimulus(1, 0); checkDut(0, "fresh r5", 0, 0, 0, 0, 0); tick();

        $display("[TB] reset mid-burst");
        for (int w = 0; w < 4; w++) pushWord(0, 32'hF0 + DW'(w));
        applyStimulus(1, 0); checkDut(0, "rst r0", 0, 0, 0, 0, 0); tick();
        applyStimulus(1, 0); checkDut(0, "rst r1", 0, 0, 0, 1, 1); tick();
        rstN = 1'b0;
        applyStimulus(1, 0);
        checkOutput("rst before edge valid", DW'(valid[0]), 1);
        checkOutput("rst before edge dat", datOut[0], 32'hF0);
        checkOutput("rst before edge busy", DW'(busy[0]), 1);
        tick();
        applyStimulus(1, 0);
        checkDut(0, "rst after edge", 0, 0, 0, 0, 0);
        checkOutput("rst after edge dat", datOut[0], 0);
        rstN = 1'b1;
        clearModel(0);
        tick();

        $display("[TB] single-beat bursts");
        for (int w = 0; w < 5; w++) pushWord(2, 32'h100 + DW'(w));
        for (int r = 0; r < 16; r++) begin
            applyStimulus(1, 0);
            case (r % 3)
                0: checkDut(2, $sformatf("single r%0d", r), 0, 0, 0, 0, 0);
                1: checkDut(2, $sformatf("single r%0d", r), 0, 0, 0, 1, 1);
                default: checkDut(2, $sformatf("single r%0d", r), 1, 32'h100 + DW'(r / 3), 1, 1, 0);
            endcase
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
